// File: rtl/snitch_icache_l0_mo.sv
// L0 instruction cache for one fetch port with several ID-tracked refills in
// flight, next-line prefetch and per-line bus-error capture.
module snitch_icache_l0_mo #(
  parameter int unsigned FETCH_AW       = 48,
  parameter int unsigned FETCH_DW       = 32,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned LINE_COUNT     = 4,
  parameter int unsigned MAX_PENDING    = 2,
  parameter int unsigned PREFETCH_DEPTH = 1,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned L0_ID          = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_valid_i,
  input  logic                  enable_prefetching_i,
  input  logic [FETCH_AW-1:0]   in_addr_i,
  input  logic                  in_valid_i,
  output logic [FETCH_DW-1:0]   in_data_o,
  output logic                  in_ready_o,
  output logic                  in_error_o,
  output logic [FETCH_AW-1:0]   out_req_addr_o,
  output logic [ID_WIDTH-1:0]   out_req_id_o,
  output logic                  out_req_valid_o,
  input  logic                  out_req_ready_i,
  input  logic [LINE_WIDTH-1:0] out_rsp_data_i,
  input  logic                  out_rsp_error_i,
  input  logic [ID_WIDTH-1:0]   out_rsp_id_i,
  input  logic                  out_rsp_valid_i,
  output logic                  out_rsp_ready_o
);
  localparam int unsigned LA = $clog2(LINE_WIDTH / 8);
  localparam int unsigned FA = $clog2(FETCH_DW / 8);
  localparam int unsigned TW = FETCH_AW - LA;
  localparam int unsigned LW = $clog2(LINE_COUNT);
  localparam int unsigned SW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

  typedef enum logic [1:0] {L_INV, L_PEND, L_VAL} lstate_e;

  lstate_e               r_st        [LINE_COUNT];
  logic [TW-1:0]         r_tag       [LINE_COUNT];
  logic [LINE_WIDTH-1:0] r_data      [LINE_COUNT];
  logic [LINE_COUNT-1:0] r_err, r_drop;
  logic [MAX_PENDING-1:0] r_slot_vld;
  logic [LW-1:0]         r_slot_line [MAX_PENDING];
  logic                  r_req_vld;
  logic [TW-1:0]         r_req_tag;
  logic [SW-1:0]         r_req_slot;
  logic [LW-1:0]         r_ptr;

  logic [TW-1:0]    w_in_tag;
  logic [LA-FA-1:0] w_woff;
  logic             w_hit, w_pmatch, w_miss;
  logic [LW-1:0]    w_hit_idx;
  logic             w_pf_vld;
  logic [TW-1:0]    w_pf_tag;
  logic             w_vic_vld;
  logic [LW-1:0]    w_vic;
  logic             w_slot_free;
  logic [SW-1:0]    w_free_slot;
  logic [SW-1:0]    w_rsp_slot;
  logic             w_rsp_acc;
  logic [LW-1:0]    w_rsp_line;
  logic             w_alloc;
  logic [TW-1:0]    w_alloc_tag;
  logic             w_unused;

  assign w_in_tag   = in_addr_i[FETCH_AW-1:LA];
  assign w_woff     = in_addr_i[LA-1:FA];
  assign w_rsp_slot = out_rsp_id_i[SW-1:0];
  assign w_rsp_line = r_slot_line[w_rsp_slot];
  // Responses to a slot nothing is waiting on (e.g. issued before a reset) are dropped.
  assign w_rsp_acc  = out_rsp_valid_i && (32'(w_rsp_slot) < MAX_PENDING) && r_slot_vld[w_rsp_slot];
  assign w_unused   = ^{in_addr_i[FA-1:0], out_rsp_id_i};

  // Tag lookup: hit on VALID lines, stall on a line already being refilled.
  always_comb begin
    w_hit = 1'b0; w_hit_idx = '0; w_pmatch = 1'b0;
    for (int i = 0; i < LINE_COUNT; i++) begin
      if (r_tag[i] == w_in_tag) begin
        if (r_st[i] == L_VAL) begin w_hit = 1'b1; w_hit_idx = LW'(i); end
        if (r_st[i] == L_PEND) w_pmatch = 1'b1;
      end
    end
    w_hit    = w_hit & in_valid_i;
    w_pmatch = w_pmatch & in_valid_i;
    w_miss   = in_valid_i & ~w_hit & ~w_pmatch;
  end

  // Prefetch candidate: lowest k whose line is neither VALID nor PENDING.
  always_comb begin
    logic [TW-1:0] v_t;
    logic          v_pres;
    v_t = '0; v_pres = 1'b0;
    w_pf_vld = 1'b0; w_pf_tag = '0;
    for (int k = PREFETCH_DEPTH; k >= 1; k--) begin
      v_t    = w_in_tag + TW'(k);
      v_pres = 1'b0;
      for (int i = 0; i < LINE_COUNT; i++)
        if (r_st[i] != L_INV && r_tag[i] == v_t) v_pres = 1'b1;
      if (!v_pres) begin w_pf_vld = 1'b1; w_pf_tag = v_t; end
    end
    w_pf_vld = w_pf_vld & w_hit & enable_prefetching_i;
  end

  // Victim: round-robin from r_ptr, never a line in flight, hit now, or filled now.
  always_comb begin
    logic [LW-1:0] v_idx;
    v_idx = '0; w_vic_vld = 1'b0; w_vic = '0;
    for (int k = LINE_COUNT - 1; k >= 0; k--) begin
      v_idx = r_ptr + LW'(k);
      if (r_st[v_idx] != L_PEND && !(w_hit && v_idx == w_hit_idx) &&
          !(w_rsp_acc && v_idx == w_rsp_line)) begin
        w_vic_vld = 1'b1; w_vic = v_idx;
      end
    end
  end

  // Lowest free refill slot.
  always_comb begin
    w_slot_free = 1'b0; w_free_slot = '0;
    for (int s = MAX_PENDING - 1; s >= 0; s--)
      if (!r_slot_vld[s]) begin w_slot_free = 1'b1; w_free_slot = SW'(s); end
  end

  // Demand misses take priority over prefetch; a flush blocks allocation this cycle.
  assign w_alloc     = ~flush_valid_i & ~r_req_vld & w_slot_free & w_vic_vld & (w_miss | w_pf_vld);
  assign w_alloc_tag = w_miss ? w_in_tag : w_pf_tag;

  // Line, slot and request-register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LINE_COUNT; i++) begin
        r_st[i] <= L_INV; r_tag[i] <= '0; r_data[i] <= '0;
      end
      for (int s = 0; s < MAX_PENDING; s++) r_slot_line[s] <= '0;
      r_err <= '0; r_drop <= '0; r_slot_vld <= '0;
      r_req_vld <= 1'b0; r_req_tag <= '0; r_req_slot <= '0; r_ptr <= '0;
    end else begin
      if (r_req_vld && out_req_ready_i) r_req_vld <= 1'b0;
      if (flush_valid_i) begin
        for (int i = 0; i < LINE_COUNT; i++) begin
          if (r_st[i] == L_VAL) begin r_st[i] <= L_INV; r_err[i] <= 1'b0; end
          if (r_st[i] == L_PEND) r_drop[i] <= 1'b1;
        end
      end
      if (w_alloc) begin
        r_st[w_vic]              <= L_PEND;
        r_tag[w_vic]             <= w_alloc_tag;
        r_err[w_vic]             <= 1'b0;
        r_drop[w_vic]            <= 1'b0;
        r_slot_vld[w_free_slot]  <= 1'b1;
        r_slot_line[w_free_slot] <= w_vic;
        r_req_vld                <= 1'b1;
        r_req_tag                <= w_alloc_tag;
        r_req_slot               <= w_free_slot;
        r_ptr                    <= w_vic + LW'(1);
      end
      // A response racing a flush, or arriving after one, leaves its line empty.
      if (w_rsp_acc) begin
        r_slot_vld[w_rsp_slot] <= 1'b0;
        if (flush_valid_i || r_drop[w_rsp_line]) begin
          r_st[w_rsp_line]   <= L_INV;
          r_drop[w_rsp_line] <= 1'b0;
          r_err[w_rsp_line]  <= 1'b0;
        end else begin
          r_st[w_rsp_line]   <= L_VAL;
          r_data[w_rsp_line] <= out_rsp_data_i;
          r_err[w_rsp_line]  <= out_rsp_error_i;
        end
      end
    end
  end

  assign in_ready_o      = w_hit;
  assign in_data_o       = w_hit ? r_data[w_hit_idx][32'(w_woff) * FETCH_DW +: FETCH_DW] : '0;
  assign in_error_o      = w_hit & r_err[w_hit_idx];
  assign out_req_valid_o = r_req_vld;
  assign out_req_addr_o  = {r_req_tag, {LA{1'b0}}};
  assign out_req_id_o    = r_req_vld ? ((ID_WIDTH'(L0_ID) << SW) | ID_WIDTH'(r_req_slot)) : '0;
  assign out_rsp_ready_o = 1'b1;
endmodule

// File: tb/tb_snitch_icache_l0_mo.sv
// Directed bench for snitch_icache_l0_mo: cold miss, out-of-order refills,
// prefetch with address wrap, flush races, error capture and async reset.
module tb_snitch_icache_l0_mo;
  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_valid_i = 1'b0;
  logic          enable_prefetching_i = 1'b0;
  logic [47:0]   in_addr_i = '0;
  logic          in_valid_i = 1'b0;
  logic [31:0]   in_data_o;
  logic          in_ready_o, in_error_o;
  logic [47:0]   out_req_addr_o;
  logic [3:0]    out_req_id_o;
  logic          out_req_valid_o;
  logic          out_req_ready_i = 1'b0;
  logic [127:0]  out_rsp_data_i = '0;
  logic          out_rsp_error_i = 1'b0;
  logic [3:0]    out_rsp_id_i = '0;
  logic          out_rsp_valid_i = 1'b0;
  logic          out_rsp_ready_o;

  int n_cmp = 0;
  int n_err = 0;

  snitch_icache_l0_mo #(
    .FETCH_AW(48), .FETCH_DW(32), .LINE_WIDTH(128), .LINE_COUNT(4),
    .MAX_PENDING(2), .PREFETCH_DEPTH(2), .ID_WIDTH(4), .L0_ID(0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_valid_i(flush_valid_i),
    .enable_prefetching_i(enable_prefetching_i),
    .in_addr_i(in_addr_i), .in_valid_i(in_valid_i), .in_data_o(in_data_o),
    .in_ready_o(in_ready_o), .in_error_o(in_error_o),
    .out_req_addr_o(out_req_addr_o), .out_req_id_o(out_req_id_o),
    .out_req_valid_o(out_req_valid_o), .out_req_ready_i(out_req_ready_i),
    .out_rsp_data_i(out_rsp_data_i), .out_rsp_error_i(out_rsp_error_i),
    .out_rsp_id_i(out_rsp_id_i), .out_rsp_valid_i(out_rsp_valid_i),
    .out_rsp_ready_o(out_rsp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Memory image: each 32-bit word holds its own byte address XOR 0xC0DE0000.
  function automatic logic [127:0] line_of(input logic [47:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = {a[31:4], 4'h0};
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = (base + 32'(4 * w)) ^ 32'hC0DE0000;
    return l;
  endfunction

  task automatic nx();
    @(negedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; in_valid_i = 1'b0; flush_valid_i = 1'b0;
    enable_prefetching_i = 1'b0; out_req_ready_i = 1'b0; out_rsp_valid_i = 1'b0;
    nx(); nx();
    rst_ni = 1'b1;
    nx();
  endtask

  task automatic req_hs(input string tag, input logic [47:0] ea, input logic [3:0] eid);
    int n;
    n = 0;
    while (!out_req_valid_o && n < 20) begin nx(); n++; end
    chk({tag, "_vld"}, 64'(out_req_valid_o), 64'd1);
    if (out_req_valid_o) begin
      chk({tag, "_addr"}, 64'(out_req_addr_o), 64'(ea));
      chk({tag, "_id"}, 64'(out_req_id_o), 64'(eid));
      out_req_ready_i = 1'b1;
      nx();
      out_req_ready_i = 1'b0;
    end
  endtask

  task automatic rsp(input logic [3:0] id, input logic [47:0] a, input logic err);
    out_rsp_valid_i = 1'b1; out_rsp_id_i = id;
    out_rsp_data_i = line_of(a); out_rsp_error_i = err;
    nx();
    out_rsp_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_rdy", 64'(in_ready_o), 0);
    chk("rst_data", 64'(in_data_o), 0);
    chk("rst_err", 64'(in_error_o), 0);
    chk("rst_rvld", 64'(out_req_valid_o), 0);
    chk("rst_raddr", 64'(out_req_addr_o), 0);
    chk("rst_rid", 64'(out_req_id_o), 0);
    chk("rst_rsprdy", 64'(out_rsp_ready_o), 1);
    do_reset();

    // Cold miss at 0x1000
    in_valid_i = 1'b1; in_addr_i = 48'h1000; #1;
    chk("t1_miss_rdy", 64'(in_ready_o), 0);
    chk("t1_req_t", 64'(out_req_valid_o), 0);
    nx();
    chk("t1_req_t1", 64'(out_req_valid_o), 1);
    req_hs("t1_req", 48'h1000, 4'd0);
    chk("t1_req_free", 64'(out_req_valid_o), 0);
    nx(); nx();
    chk("t1_stall", 64'(in_ready_o), 0);
    rsp(4'd0, 48'h1000, 1'b0);
    chk("t1_rdy", 64'(in_ready_o), 1);
    chk("t1_d0", 64'(in_data_o), 64'hC0DE1000);
    in_addr_i = 48'h1008; #1;
    chk("t1_d8", 64'(in_data_o), 64'hC0DE1008);
    chk("t1_err", 64'(in_error_o), 0);
    nx();
    chk("t1_nopf", 64'(out_req_valid_o), 0);
    in_valid_i = 1'b0; #1;
    chk("t1_noval_rdy", 64'(in_ready_o), 0);
    chk("t1_noval_data", 64'(in_data_o), 0);

    // Two outstanding misses answered out of order; third stalls on slots
    do_reset();
    in_valid_i = 1'b1; in_addr_i = 48'h1000; nx();
    req_hs("t2_a", 48'h1000, 4'd0);
    in_addr_i = 48'h2000; nx();
    req_hs("t2_b", 48'h2000, 4'd1);
    in_addr_i = 48'h3000; nx(); nx();
    chk("t2_stall_req", 64'(out_req_valid_o), 0);
    chk("t2_stall_rdy", 64'(in_ready_o), 0);
    rsp(4'd1, 48'h2000, 1'b0);
    chk("t2_slot_lat", 64'(out_req_valid_o), 0);
    nx();
    chk("t2_c_now", 64'(out_req_valid_o), 1);
    req_hs("t2_c", 48'h3000, 4'd1);
    rsp(4'd0, 48'h1000, 1'b0);
    in_addr_i = 48'h1004; #1;
    chk("t2_h1_rdy", 64'(in_ready_o), 1);
    chk("t2_h1_data", 64'(in_data_o), 64'hC0DE1004);
    in_addr_i = 48'h2008; #1;
    chk("t2_h2_rdy", 64'(in_ready_o), 1);
    chk("t2_h2_data", 64'(in_data_o), 64'hC0DE2008);
    in_valid_i = 1'b0;

    // Prefetch depth 2, then wrap past the top of the address space
    do_reset();
    in_valid_i = 1'b1; in_addr_i = 48'h1000; nx();
    req_hs("t3_a", 48'h1000, 4'd0);
    rsp(4'd0, 48'h1000, 1'b0);
    chk("t3_hit", 64'(in_ready_o), 1);
    enable_prefetching_i = 1'b1; #1;
    nx();
    req_hs("t3_pf1", 48'h1010, 4'd0);
    req_hs("t3_pf2", 48'h1020, 4'd1);
    nx(); nx();
    chk("t3_pf_done", 64'(out_req_valid_o), 0);
    enable_prefetching_i = 1'b0;
    rsp(4'd1, 48'h1020, 1'b0);
    rsp(4'd0, 48'h1010, 1'b0);
    in_addr_i = 48'h1024; #1;
    chk("t3_pf2_data", 64'(in_data_o), 64'hC0DE1024);
    in_addr_i = 48'h1018; #1;
    chk("t3_pf1_data", 64'(in_data_o), 64'hC0DE1018);
    in_addr_i = 48'hFFFF_FFFF_FFF0; #1;
    nx();
    req_hs("t3_hi", 48'hFFFF_FFFF_FFF0, 4'd0);
    rsp(4'd0, 48'hFFFF_FFFF_FFF0, 1'b0);
    chk("t3_hi_data", 64'(in_data_o), 64'h3F21FFF0);
    enable_prefetching_i = 1'b1; #1;
    nx();
    req_hs("t3_wrap", 48'h0, 4'd0);
    req_hs("t3_wrap2", 48'h10, 4'd1);
    enable_prefetching_i = 1'b0;

    // Flush during a refill, then flush racing the response
    do_reset();
    in_valid_i = 1'b1; in_addr_i = 48'h1000; nx();
    req_hs("t4_a", 48'h1000, 4'd0);
    flush_valid_i = 1'b1; nx(); flush_valid_i = 1'b0;
    rsp(4'd0, 48'h1000, 1'b0);
    chk("t4_drop_rdy", 64'(in_ready_o), 0);
    chk("t4_refetch_t", 64'(out_req_valid_o), 0);
    nx();
    req_hs("t4_refetch", 48'h1000, 4'd0);
    flush_valid_i = 1'b1;
    rsp(4'd0, 48'h1000, 1'b0);
    flush_valid_i = 1'b0; #1;
    chk("t4_race_rdy", 64'(in_ready_o), 0);
    nx();
    req_hs("t4_refetch2", 48'h1000, 4'd0);
    rsp(4'd0, 48'h1000, 1'b0);
    chk("t4_hit", 64'(in_ready_o), 1);

    // Bus error captured per line, cleared by flush
    do_reset();
    in_valid_i = 1'b1; in_addr_i = 48'h4000; nx();
    req_hs("t5_a", 48'h4000, 4'd0);
    rsp(4'd0, 48'h4000, 1'b1);
    chk("t5_rdy", 64'(in_ready_o), 1);
    chk("t5_err", 64'(in_error_o), 1);
    chk("t5_data", 64'(in_data_o), 64'hC0DE4000);
    flush_valid_i = 1'b1; nx(); flush_valid_i = 1'b0; #1;
    chk("t5_fl_rdy", 64'(in_ready_o), 0);
    chk("t5_fl_err", 64'(in_error_o), 0);

    // Async reset while a request is outstanding; late response is stale
    do_reset();
    in_valid_i = 1'b1; in_addr_i = 48'h1000; nx();
    chk("t6_pre", 64'(out_req_valid_o), 1);
    #2;
    rst_ni = 1'b0; in_valid_i = 1'b0; #1;
    chk("t6_rvld", 64'(out_req_valid_o), 0);
    chk("t6_raddr", 64'(out_req_addr_o), 0);
    chk("t6_rid", 64'(out_req_id_o), 0);
    chk("t6_rdy", 64'(in_ready_o), 0);
    chk("t6_data", 64'(in_data_o), 0);
    chk("t6_err", 64'(in_error_o), 0);
    chk("t6_rsprdy", 64'(out_rsp_ready_o), 1);
    nx();
    rst_ni = 1'b1;
    nx();
    rsp(4'd0, 48'h1000, 1'b0);
    in_valid_i = 1'b1; in_addr_i = 48'h1000; #1;
    chk("t6_stale_rdy", 64'(in_ready_o), 0);
    nx();
    req_hs("t6_refetch", 48'h1000, 4'd0);
    in_valid_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
